ref_clk_training_ctrl: RTL

//  Fabric-side training engine for the DDR3 reference-clock training IOD.

---
 rtl/ref_clk_training_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ref_clk_training_ctrl.sv
// Purpose : fabric-side training engine for the DDR3 reference-clock IOD; sweeps the
//           input delay line forward, finds the first stable clock edge, backs off a
//           fixed number of taps and reports the final tap.
// Latency : one tap step every SETTLE_CYCLES+2 cycles forward, SETTLE_CYCLES+1 back.
// Backpressure : none; TRAIN_START is a one-cycle request ignored while busy.
// Ports:
//   i_fab_clk / i_reset            fabric clock, async active-high reset
//   i_train_start                  one-cycle start request
//   i_rx_data[7:0]                 deserialised ref-clock sample from the IOD
//   i_delay_line_out_of_range      IOD delay line at its end stop (aborts to FAIL)
//   i_eye_monitor_early/late       IOD eye-monitor flags
//   o_delay_line_load/move/direction, o_eye_monitor_clear_flags   IOD controls
//   o_busy, o_train_done, o_train_err, o_tap_count[7:0], o_eye_flags[1:0]  status
module ref_clk_training_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_TAPS      = 255,
  parameter int STABLE_CNT    = 2,
  parameter int BACKOFF_TAPS  = 4
) (
  input  logic       i_fab_clk,
  input  logic       i_reset,
  input  logic       i_train_start,
  input  logic [7:0] i_rx_data,
  input  logic       i_delay_line_out_of_range,
  input  logic       i_eye_monitor_early,
  input  logic       i_eye_monitor_late,
  output logic       o_delay_line_load,
  output logic       o_delay_line_move,
  output logic       o_delay_line_direction,
  output logic       o_eye_monitor_clear_flags,
  output logic       o_busy,
  output logic       o_train_done,
  output logic       o_train_err,
  output logic [7:0] o_tap_count,
  output logic [1:0] o_eye_flags
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  MAX_TAP_L   = 8'(MAX_TAPS);
  localparam logic [7:0]  STABLE_L    = 8'(STABLE_CNT);
  localparam logic [7:0]  BACKOFF_L   = 8'(BACKOFF_TAPS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_MOVE, S_BACK, S_DONE, S_FAIL
  } state_t;

  state_t      r_state;
  logic [15:0] r_settle_cnt;
  logic [7:0]  r_ref;
  logic        r_ref_vld;
  logic [7:0]  r_mismatch;
  logic [7:0]  r_edge_tap;
  logic        r_backoff;
  logic        r_load, r_move, r_dir, r_clear;
  logic        r_busy, r_done, r_err;
  logic [7:0]  r_tap;
  logic [1:0]  r_eye;

  logic [7:0]  w_mismatch_inc;
  logic [7:0]  w_edge_sel;
  logic [7:0]  w_target;

  assign w_mismatch_inc = r_mismatch + 8'd1;
  // On the very first mismatch the edge tap is being recorded this cycle, so
  // the back-off target has to be derived from the current tap directly.
  assign w_edge_sel     = (r_mismatch == 8'd0) ? r_tap : r_edge_tap;
  assign w_target       = (w_edge_sel > BACKOFF_L) ? (w_edge_sel - BACKOFF_L) : 8'd0;

  always_ff @(posedge i_fab_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_ref        <= '0;
      r_ref_vld    <= 1'b0;
      r_mismatch   <= '0;
      r_edge_tap   <= '0;
      r_backoff    <= 1'b0;
      r_load       <= 1'b0;
      r_move       <= 1'b0;
      r_dir        <= 1'b0;
      r_clear      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_tap        <= '0;
      r_eye        <= '0;
    end else begin
      r_load  <= 1'b0;
      r_move  <= 1'b0;
      r_clear <= 1'b0;

      // Eye flags follow the IOD: cleared by the clear pulse, sticky otherwise,
      // and frozen once training has finished.
      if (r_state != S_DONE && r_state != S_FAIL) begin
        if (r_clear) r_eye <= 2'b00;
        else         r_eye <= r_eye | {i_eye_monitor_late, i_eye_monitor_early};
      end

      if (r_busy && i_delay_line_out_of_range) begin
        r_state <= S_FAIL;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_FAIL: begin
            if (i_train_start) begin
              r_state    <= S_LOAD;
              r_load     <= 1'b1;
              r_clear    <= 1'b1;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_err      <= 1'b0;
              r_tap      <= '0;
              r_ref      <= '0;
              r_ref_vld  <= 1'b0;
              r_mismatch <= '0;
              r_edge_tap <= '0;
              r_backoff  <= 1'b0;
            end
          end
          S_LOAD: begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= '0;
          end
          S_SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_settle_cnt <= '0;
              if (!r_backoff) begin
                r_state <= S_SAMPLE;
              end else if (r_tap > w_target) begin
                r_state <= S_BACK;
                r_move  <= 1'b1;
                r_dir   <= 1'b0;
                r_clear <= 1'b1;
                r_tap   <= r_tap - 8'd1;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_settle_cnt <= r_settle_cnt + 16'd1;
            end
          end
          S_SAMPLE: begin
            if (r_ref_vld && (i_rx_data != r_ref) && (w_mismatch_inc >= STABLE_L)) begin
              // Edge confirmed: start backing off (the BACK state carries the move pulse).
              r_mismatch <= w_mismatch_inc;
              r_edge_tap <= w_edge_sel;
              r_backoff  <= 1'b1;
              if (r_tap > w_target) begin
                r_state <= S_BACK;
                r_move  <= 1'b1;
                r_dir   <= 1'b0;
                r_clear <= 1'b1;
                r_tap   <= r_tap - 8'd1;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              if (!r_ref_vld) begin
                r_ref     <= i_rx_data;
                r_ref_vld <= 1'b1;
              end else if (i_rx_data != r_ref) begin
                r_mismatch <= w_mismatch_inc;
                r_edge_tap <= w_edge_sel;
              end else begin
                r_mismatch <= '0;
                r_edge_tap <= '0;
              end
              if (r_ref_vld && r_tap >= MAX_TAP_L) begin
                r_state <= S_FAIL;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
              end else begin
                r_state <= S_MOVE;
                r_move  <= 1'b1;
                r_dir   <= 1'b1;
                r_clear <= 1'b1;
                r_tap   <= r_tap + 8'd1;
              end
            end
          end
          S_MOVE, S_BACK: begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= '0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_delay_line_load         = r_load;
  assign o_delay_line_move         = r_move;
  assign o_delay_line_direction    = r_dir;
  assign o_eye_monitor_clear_flags = r_clear;
  assign o_busy                    = r_busy;
  assign o_train_done              = r_done;
  assign o_train_err               = r_err;
  assign o_tap_count               = r_tap;
  assign o_eye_flags               = r_eye;

endmodule
